// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the multi-channel LED driver.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    // Half-period giving a 1 Hz blink: toggle every CLK_MHZ*500000 cycles.
    function automatic int unsigned default_half_period(input int unsigned clk_mhz);
        return clk_mhz * 500000 - 1;
    endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// Configuration write port of the LED driver: one-cycle write strobe plus payload.
interface led_ctrl_if
    import led_ctrl_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 32,
    parameter int PWM_BITS = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    led_mode_t           cfg_mode;
    logic [DIV_W-1:0]    cfg_half_period;
    logic [PWM_BITS-1:0] cfg_duty;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_half_period, cfg_duty
    );

    modport slave (
        input cfg_we, cfg_ch, cfg_mode, cfg_half_period, cfg_duty
    );

endinterface

// File: rtl/led_ctrl_channel.sv
// One LED channel: mode, blink counter/phase and PWM duty.
// Optional macro LED_BREATHE_EN: in PWM mode the duty ramps up and down as a
// triangle wave, one step per half-period expiry.
module led_channel
    import led_ctrl_pkg::*;
#(
    parameter int CLK_MHZ  = 50,
    parameter int DIV_W    = 32,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  led_mode_t           mode_i,
    input  logic [DIV_W-1:0]    half_period_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_next_o
);
    localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(default_half_period(CLK_MHZ));

    led_mode_t           mode_q;
    logic [DIV_W-1:0]    half_q;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                expire;
    logic                phase_run;

    assign expire    = (cnt_q == half_q);
    // Phase the running blink would reach this edge, ignoring any write.
    assign phase_run = expire ? ~phase_q : phase_q;

`ifdef LED_BREATHE_EN
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    logic dir_q, dir_d;
    logic step_up;
    // At either end of the ramp the step direction is forced inward.
    assign step_up = dir_q ? (duty_q != DUTY_MAX) : (duty_q == '0);
`endif

    // Next-state for counter, phase and duty; a config write restarts the channel.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        duty_d  = duty_q;
`ifdef LED_BREATHE_EN
        dir_d   = dir_q;
`endif
        case (mode_q)
            LED_BLINK: begin
                if (expire) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            LED_PWM: begin
`ifdef LED_BREATHE_EN
                if (expire) begin
                    cnt_d  = '0;
                    duty_d = step_up ? duty_q + PWM_BITS'(1) : duty_q - PWM_BITS'(1);
                    dir_d  = step_up ? (duty_d != DUTY_MAX) : (duty_d == '0);
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
`else
                cnt_d = '0;
`endif
            end
            default: cnt_d = '0;
        endcase
        if (wr_en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            duty_d  = duty_i;
`ifdef LED_BREATHE_EN
            dir_d   = 1'b1;
`endif
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= LED_OFF;
            half_q  <= HALF_RST;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            duty_q  <= '0;
`ifdef LED_BREATHE_EN
            dir_q   <= 1'b1;
`endif
        end else begin
            if (wr_en_i) begin
                mode_q <= mode_i;
                half_q <= half_period_i;
            end
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            duty_q  <= duty_d;
`ifdef LED_BREATHE_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // LED value to be registered at the top; blink follows the phase it reaches this edge.
    always_comb begin
        led_next_o = 1'b0;
        case (mode_q)
            LED_OFF:   led_next_o = 1'b0;
            LED_ON:    led_next_o = 1'b1;
            LED_BLINK: led_next_o = phase_run;
            LED_PWM:   led_next_o = (pwm_cnt_i < duty_q);
            default:   led_next_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED driver top: shared PWM counter, write decode, registered LEDs.
// Optional macro LED_BREATHE_EN enables triangle-wave duty ramping in PWM mode.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CLK_MHZ  = 50,
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 32,
    parameter int PWM_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    led_ctrl_if.slave         cfg,
    output logic [NUM_CH-1:0] led
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [NUM_CH-1:0]   led_q;
    logic [NUM_CH-1:0]   led_d;

    // Free-running PWM frame counter shared by all channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        end
    end

    // One channel per LED; an out-of-range cfg_ch matches no channel.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic wr_en;
            assign wr_en = cfg.cfg_we && (cfg.cfg_ch == CH_W'(gi));

            led_channel #(
                .CLK_MHZ  (CLK_MHZ),
                .DIV_W    (DIV_W),
                .PWM_BITS (PWM_BITS)
            ) u_ch (
                .clk           (clk),
                .rst           (rst),
                .wr_en_i       (wr_en),
                .mode_i        (cfg.cfg_mode),
                .half_period_i (cfg.cfg_half_period),
                .duty_i        (cfg.cfg_duty),
                .pwm_cnt_i     (pwm_cnt_q),
                .led_next_o    (led_d[gi])
            );
        end
    endgenerate

    // Registered LED outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: vector table, hand sequences and random
// stimulus checked each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_led_ctrl;
    import led_ctrl_pkg::*;

    localparam int CLK_MHZ  = 50;
    localparam int NUM_CH   = 5;
    localparam int DIV_W    = 32;
    localparam int PWM_BITS = 8;
    localparam int CH_W     = 3;
    localparam int PWM_MOD  = 1 << PWM_BITS;
    localparam longint HP_DEFAULT = 64'd24999999;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] led;

    led_ctrl_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .PWM_BITS(PWM_BITS)) cfg_bus ();

    led_ctrl #(
        .CLK_MHZ  (CLK_MHZ),
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cfg (cfg_bus.slave),
        .led (led)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: per-channel settings plus edges elapsed since last write.
    int                m_mode [NUM_CH];
    longint            m_hp   [NUM_CH];
    int                m_duty [NUM_CH];
    bit                m_up   [NUM_CH];
    longint            m_age  [NUM_CH];
    int                m_pwm;
    logic [NUM_CH-1:0] led_exp;

    typedef struct {
        int ch;
        int mode;
        int duty;
        int exp_led;
    } vec_t;
    vec_t vec [11];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic breathe_step(input int c);
        if (m_up[c]) begin
            if (m_duty[c] == PWM_MOD - 1) begin m_up[c] = 1'b0; m_duty[c] = PWM_MOD - 2; end
            else begin m_duty[c]++; if (m_duty[c] == PWM_MOD - 1) m_up[c] = 1'b0; end
        end else begin
            if (m_duty[c] == 0) begin m_up[c] = 1'b1; m_duty[c] = 1; end
            else begin m_duty[c]--; if (m_duty[c] == 0) m_up[c] = 1'b1; end
        end
    endtask

    // Advance the model by one clock edge with the inputs present at that edge.
    task automatic model_edge(input bit r, input bit we, input int ch, input int mode,
                              input longint hp, input int duty);
        if (r) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = 0; m_hp[c] = HP_DEFAULT; m_duty[c] = 0; m_up[c] = 1'b1; m_age[c] = 0;
            end
            m_pwm   = 0;
            led_exp = '0;
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            case (m_mode[c])
                0:       led_exp[c] = 1'b0;
                1:       led_exp[c] = 1'b1;
                2:       led_exp[c] = (((m_age[c] + 1) / (m_hp[c] + 1)) % 2) != 0;
                default: led_exp[c] = (m_pwm < m_duty[c]);
            endcase
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (we && ch == c) begin
                m_mode[c] = mode; m_hp[c] = hp; m_duty[c] = duty; m_up[c] = 1'b1; m_age[c] = 0;
            end else begin
                m_age[c]++;
`ifdef LED_BREATHE_EN
                if (m_mode[c] == 3 && (m_age[c] % (m_hp[c] + 1)) == 0) breathe_step(c);
`endif
            end
        end
        m_pwm = (m_pwm + 1) % PWM_MOD;
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        model_edge(rst, cfg_bus.cfg_we, int'(cfg_bus.cfg_ch), int'(cfg_bus.cfg_mode),
                   longint'(cfg_bus.cfg_half_period), int'(cfg_bus.cfg_duty));
        #1;
        check(name, longint'(led), longint'(led_exp));
    endtask

    task automatic drive_write(input int ch, input int mode, input longint hp, input int duty);
        cfg_bus.cfg_we          = 1'b1;
        cfg_bus.cfg_ch          = CH_W'(ch);
        cfg_bus.cfg_mode        = led_mode_t'(mode);
        cfg_bus.cfg_half_period = DIV_W'(hp);
        cfg_bus.cfg_duty        = PWM_BITS'(duty);
        tick("write_edge");
        cfg_bus.cfg_we = 1'b0;
        $display("write ch=%0d mode=%0d hp=%0d duty=%0d led=%b", ch, mode, hp, duty, led);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick("reset");
        tick("reset");
        rst = 1'b0;
    endtask

    initial begin
        int hi;
        int duties [3];

        vec[0]  = '{ch: 1, mode: 1, duty: 0, exp_led: 5'b00010};
        vec[1]  = '{ch: 3, mode: 1, duty: 0, exp_led: 5'b01010};
        vec[2]  = '{ch: 1, mode: 0, duty: 0, exp_led: 5'b01000};
        vec[3]  = '{ch: 5, mode: 1, duty: 0, exp_led: 5'b01000};
        vec[4]  = '{ch: 6, mode: 1, duty: 0, exp_led: 5'b01000};
        vec[5]  = '{ch: 4, mode: 1, duty: 0, exp_led: 5'b11000};
        vec[6]  = '{ch: 7, mode: 0, duty: 0, exp_led: 5'b11000};
        vec[7]  = '{ch: 0, mode: 3, duty: 0, exp_led: 5'b11000};
        vec[8]  = '{ch: 3, mode: 0, duty: 0, exp_led: 5'b10000};
        vec[9]  = '{ch: 4, mode: 0, duty: 0, exp_led: 5'b00000};
        vec[10] = '{ch: 0, mode: 0, duty: 0, exp_led: 5'b00000};
        duties  = '{64, 0, 255};

        cfg_bus.cfg_we          = 1'b0;
        cfg_bus.cfg_ch          = '0;
        cfg_bus.cfg_mode        = LED_OFF;
        cfg_bus.cfg_half_period = '0;
        cfg_bus.cfg_duty        = '0;

        // Reset state and idle
        do_reset();
        check("led_after_reset", longint'(led), 0);
        check("half_period_rst", longint'(dut.g_ch[2].u_ch.half_q), HP_DEFAULT);
        repeat (100) tick("idle");
        $display("reset/idle done led=%b", led);

        // Vector table: write then one edge later compare the LED pattern
        for (int i = 0; i < 11; i++) begin
            drive_write(vec[i].ch, vec[i].mode, 5, vec[i].duty);
            tick("vec_follow");
            check($sformatf("vec%0d", i), longint'(led), longint'(vec[i].exp_led));
        end

        // BLINK ch2, half_period=3: first rise 4 edges after write, toggle every 4
        drive_write(2, 2, 3, 0);
        for (int k = 1; k <= 14; k++) begin
            tick("blink");
            check($sformatf("blink_k%0d", k), longint'(led[2]), longint'((k / 4) % 2));
        end
        drive_write(2, 2, 3, 0);
        for (int k = 1; k <= 9; k++) begin
            tick("blink_rewrite");
            check($sformatf("blink_rw_k%0d", k), longint'(led[2]), longint'((k / 4) % 2));
        end
        drive_write(2, 0, 0, 0);
        tick("blink_off");

`ifndef LED_BREATHE_EN
        // PWM ch0: high cycles per 256-cycle frame equal the duty
        for (int d = 0; d < 3; d++) begin
            drive_write(0, 3, 0, duties[d]);
            hi = 0;
            repeat (PWM_MOD) begin
                tick("pwm");
                hi += int'(led[0]);
            end
            check($sformatf("pwm_high_duty%0d", duties[d]), hi, duties[d]);
            $display("pwm duty=%0d high=%0d", duties[d], hi);
        end
        drive_write(0, 0, 0, 0);
`endif

        // Reset coincident with a write: the write is lost, full reset state
        drive_write(1, 1, 0, 0);
        drive_write(2, 2, 7, 0);
        tick("pre_rst");
        rst = 1'b1;
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_ch = CH_W'(2); cfg_bus.cfg_mode = LED_ON;
        cfg_bus.cfg_half_period = DIV_W'(9);
        tick("rst_with_we");
        cfg_bus.cfg_we = 1'b0;
        rst = 1'b0;
        check("half_after_rst_we", longint'(dut.g_ch[2].u_ch.half_q), HP_DEFAULT);
        repeat (10) begin
            tick("post_rst");
            check("post_rst_led", longint'(led), 0);
        end
        $display("reset-with-write done led=%b", led);

`ifdef LED_BREATHE_EN
        // Breathe: duty 254, half_period 0 -> 254,255,254,...,0,1,...,255
        drive_write(0, 3, 0, 254);
        check("breathe_t0", longint'(dut.g_ch[0].u_ch.duty_q), 254);
        for (int t = 1; t <= 511; t++) begin
            tick("breathe");
            check($sformatf("breathe_t%0d", t), longint'(dut.g_ch[0].u_ch.duty_q),
                  longint'((t <= 256) ? (256 - t) : (t - 256)));
        end
        $display("breathe ramp done");
        drive_write(0, 0, 0, 0);
`endif

        // Random writes and occasional resets, model checked every edge
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                $display("random reset");
            end else if ($urandom_range(0, 7) == 0) begin
                drive_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                            longint'($urandom_range(0, 9)), int'($urandom_range(0, 255)));
            end else begin
                tick("random");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
- Parametrised multi-channel LED driver; successor to the single fixed-rate blinker.
- Each channel is runtime-configured through a single-cycle write port to one of four modes: OFF, ON, BLINK (programmable half-period), PWM (programmable duty).
- Sits at top level next to the core; drives board LEDs directly.

Parameters:
- CLK_MHZ, 50, input clock frequency in MHz; sets the reset-default blink half-period.
- NUM_CH, 4, number of LED channels (1..32).
- DIV_W, 32, width of the blink half-period counter.
- PWM_BITS, 8, PWM counter and duty resolution.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  config write strobe, one cycle per write.
- cfg_ch  in  CH_W = max(1,$clog2(NUM_CH))  target channel index.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM.
- cfg_half_period  in  DIV_W  BLINK: toggle every cfg_half_period+1 cycles.
- cfg_duty  in  PWM_BITS  PWM on-count per 2^PWM_BITS-cycle frame.
- led  out  NUM_CH  registered LED outputs, active-high.

Behaviour:
- Reset (rst=1 at posedge clk):
  - All channels: mode=OFF, counter=0, phase=0, duty=0.
  - half_period = CLK_MHZ*500000-1 (24999999 at 50 MHz).
  - led=0; shared PWM counter=0.
  - rst overrides a coincident cfg_we; a write in the same cycle is lost.
- Config write:
  - On the posedge with cfg_we=1 and cfg_ch<NUM_CH, the channel latches mode, half_period and duty.
  - The same write clears that channel's counter and phase to 0.
  - cfg_ch>=NUM_CH: write ignored, no state changes.
  - Other channels are unaffected.
- Latency: config latched at edge N; led reflects the new mode from edge N+1.
- OFF: led=0. ON: led=1. Counters are held at 0 in both modes.
- BLINK:
  - Counter increments each cycle.
  - When counter==half_period: counter<=0 and phase<=~phase.
  - led=phase.
  - First toggle to 1 occurs half_period+1 cycles after the write edge.
  - half_period=0 toggles every cycle.
  - Counter compare is equality on DIV_W bits; no overflow is possible.
- PWM:
  - One shared free-running PWM_BITS counter, wrapping 2^PWM_BITS-1 -> 0.
  - led = (pwm_cnt < duty), evaluated each cycle, then registered.
  - duty=0: never on. duty=2^PWM_BITS-1: off exactly 1 cycle per frame.
  - PWM writes do not reset the shared counter.
- Reconfiguring a channel mid-blink or mid-PWM takes effect per the latency rule with no glitch beyond one cycle.

Optional Feature:
- Macro LED_BREATHE_EN.
- Defined:
  - In PWM mode the per-channel duty ramps automatically. Each half_period expiry (same counter as BLINK) steps duty by +1 while the direction bit is up, or by -1 while it is down.
  - Direction flips to down when duty reaches 2^PWM_BITS-1 and to up when it reaches 0, giving a triangle wave.
  - cfg write loads the starting duty from cfg_duty and sets direction=up.
- Undefined:
  - Duty in PWM mode stays static at the written value.
  - The per-channel counter is held at 0 in PWM mode.
  - No direction register is synthesised.

Decomposition:
- Package led_ctrl_pkg holds:
  - typedef enum logic[1:0] led_mode_t {LED_OFF, LED_ON, LED_BLINK, LED_PWM};
  - function default_half_period(CLK_MHZ).
- Sub-module led_channel, one instance per channel via generate:
  - Holds mode, half_period, counter, phase and duty (plus direction under LED_BREATHE_EN).
  - Takes a per-channel write enable and the shared pwm_cnt.
  - Outputs the next led bit.
- Top level holds the shared PWM counter, decodes cfg_ch and registers led.

Test Plan:
- rst=1 for 2 cycles, then idle 100 cycles -> led==0 throughout; internal half_period==24999999.
- Write ch1 ON at edge N -> led[1]=1 from N+1; led[0], led[2] and led[3] remain 0.
- Write ch2 BLINK, half_period=3 -> led[2] toggles every 4 cycles, first rise 4 cycles after the write; re-write at mid-phase -> phase restarts from 0.
- Write ch0 PWM, duty=64, PWM_BITS=8 -> exactly 64 high cycles per 256-cycle frame; duty=0 -> 0 high cycles; duty=255 -> 255 high cycles.
- cfg_we with cfg_ch=5 (NUM_CH=4), and cfg_we coincident with rst -> no channel state change / full reset state respectively.
- LED_BREATHE_EN, PWM duty=254, half_period=0 -> duty sequence 254, 255, 254, 253 …; both turnarounds (at 255 and at 0) checked.
